lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Multi-cycle load/store sequencer between the core's execute stage and the single-port, byte-lane data memory. It accepts one load or store request at a time and decodes RISC-V `funct3` width and signedness. Byte and half-word stores are carried out as read-modify-write, because the memory port has no byte enables. The block replaces ad-hoc memory handling in the ALU path with a handshaked controller that detects misaligned and illegal accesses.

## Interface
- No parameters; data and address widths are fixed at 32.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  request valid; sampled only when `ready`=1.
- `we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  access type.
  - Loads: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu.
  - Stores: 0 sb, 1 sh, 2 sw.
- `addr`  in  32  byte address (base + offset already summed).
- `wdata`  in  32  store data; low byte or half-word used for sb/sh.
- `ready`  out  1  controller idle and able to accept a request.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: access was misaligned or illegal.
- `rdata`  out  32  extended load result; holds until the next successful load completes.
- `mem_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `mem_re`  out  1  read strobe.
- `mem_we`  out  1  write strobe; the memory writes all 4 lanes on the clock edge.
- `mem_wdata`  out  32  write word; lane n = bits [8n+7:8n], little-endian.
- `mem_rdata`  in  32  read word; combinational from `mem_addr`, valid in the same cycle.

## Operation
- States: IDLE, RD, WB, RESP. Memory outputs are Moore outputs, decoded from the state and the latched request registers.
- IDLE:
  - `ready`=1.
  - On `req`, latch `we`, `funct3`, `addr` and `wdata`, then check the request.
  - Illegal encodings: load `funct3` ∈ {3,6,7}; store `funct3` ≥ 3.
  - Misaligned: half-word with `addr[0]`=1; word with `addr[1:0]`≠0.
  - Illegal or misaligned → RESP with the error flag set.
  - Legal load, sb or sh → RD.
  - Legal sw → WB.
- RD:
  - `mem_re`=1, `mem_addr` = latched word address.
  - Capture `mem_rdata` into the internal word register at the clock edge.
  - Next state: load → RESP; sb/sh → WB.
- WB:
  - `mem_we`=1, `mem_addr` = word address.
  - sw: `mem_wdata` = `wdata`.
  - sb: captured word with lane `addr[1:0]` replaced by `wdata[7:0]`.
  - sh: captured word with lanes {2·addr[1], 2·addr[1]+1} replaced by `wdata[15:0]`.
  - Next state: → RESP.
- RESP:
  - `done`=1 and `err` = error flag.
  - For a successful load, `rdata` is updated on entry to RESP from the captured word:
    - lb/lbu: lane `addr[1:0]`, sign- or zero-extended.
    - lh/lhu: half `addr[1]`, sign- or zero-extended.
    - lw: whole word.
  - Next state: → IDLE.
- `req` while not in IDLE is ignored. The requester must hold `req` and its fields until it sees `ready`=1.
- An errored access never asserts `mem_re` or `mem_we`, and leaves `rdata` unchanged.
- `mem_addr` = 0 and `mem_wdata` = 0 in IDLE and RESP.

## Timing
- Reset (asynchronous, immediate): state = IDLE.
  - Output values: `ready`=1, `done`=0, `err`=0, `rdata`=0, `mem_re`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - Reset mid-WB drops `mem_we` without waiting for a clock edge; that write is abandoned.
  - No partial `done` is produced for the interrupted access.
- Cycle 0 is the IDLE cycle in which the request is accepted. `done` is asserted in:
  - cycle 1 for an error;
  - cycle 2 for a load or sw;
  - cycle 3 for sb/sh.
- `mem_we` is high for exactly one cycle per legal store; `mem_re` for exactly one cycle per load, sb or sh.
- `ready` returns to 1 in the cycle after `done`. Minimum request spacing is therefore 2, 3 or 4 cycles respectively.
- `err` is 0 whenever `done` is 0.

## Test plan
- Load extension, memory word 0x100 = 0x8899AABB:
  - lb @0x103 → `rdata` = 0xFFFFFF88, `done` in cycle 2, one `mem_re` pulse with `mem_addr` = 0x100.
  - lbu @0x101 → 0x000000AA.
  - lhu @0x102 → 0x00008899.
  - lh @0x100 → 0xFFFFAABB.
- sb @0x101, `wdata` = 0x12345677, word 0x8899AABB:
  - RD then WB, with `mem_wdata` = 0x889977BB.
  - `done` in cycle 3.
  - A subsequent lw @0x100 returns 0x889977BB.
- sw @0x104, `wdata` = 0xDEADBEEF:
  - No `mem_re`.
  - `mem_we` is a single-cycle pulse in cycle 1, with `mem_addr` = 0x104.
  - `done` in cycle 2, `err` = 0.
- Error accesses:
  - sw @0x102 → `done` and `err` in cycle 1, no `mem_we`.
  - lh @0x101 → `err`=1, previous `rdata` retained.
  - Load `funct3` = 3 → `err`=1.
- Back-to-back: `req` held high across three lw requests → accepted every 3 cycles; no request is accepted while `ready`=0.
- Reset: assert `rst` during the WB of an sh → `mem_we` falls asynchronously, target word unchanged, all outputs at reset values. After release, the next lw completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: multi-cycle load/store sequencer for a single-port data memory
// without byte enables; byte and half-word stores are done as read-modify-write.
module lsu_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]  state;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] word_q;
  logic        err_q;

  logic        req_illegal;
  logic        req_misaligned;
  logic        req_bad;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;
  logic [31:0] store_word;

  // Request legality is judged on the live inputs so the error path can go
  // straight to RESP without touching memory.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    if (we) begin
      req_illegal = (funct3 >= 3'd3);
    end else begin
      req_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    end
    case (funct3[1:0])
      2'd1:    req_misaligned = addr[0];
      2'd2:    req_misaligned = (addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
    req_bad = req_illegal || req_misaligned;
  end

  always_comb begin
    sel_byte = mem_rdata[{lat_addr[1:0], 3'b000} +: 8];
    sel_half = mem_rdata[{lat_addr[1], 4'b0000} +: 16];
    case (lat_f3)
      3'd0:    load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'd1:    load_ext = {{16{sel_half[15]}}, sel_half};
      3'd4:    load_ext = {24'd0, sel_byte};
      3'd5:    load_ext = {16'd0, sel_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Sub-word stores merge into the word captured during RD.
  always_comb begin
    store_word = word_q;
    case (lat_f3)
      3'd0:    store_word[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
      3'd1:    store_word[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
      default: store_word = lat_wdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_f3    <= 3'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      word_q    <= 32'd0;
      err_q     <= 1'b0;
      rdata     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_f3    <= funct3;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            err_q     <= req_bad;
            if (req_bad) begin
              state <= RESP;
            end else if (we && (funct3 == 3'd2)) begin
              state <= WB;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          word_q <= mem_rdata;
          if (lat_we) begin
            state <= WB;
          end else begin
            rdata <= load_ext;
            state <= RESP;
          end
        end
        WB:      state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready     = (state == IDLE);
  assign done      = (state == RESP);
  assign err       = (state == RESP) && err_q;
  assign mem_re    = (state == RD);
  assign mem_we    = (state == WB);
  assign mem_addr  = (mem_re || mem_we) ? {lat_addr[31:2], 2'b00} : 32'd0;
  assign mem_wdata = mem_we ? store_word : 32'd0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed table-driven bench for lsu_mem_ctrl with a
// behavioural single-port word memory.
module tb_lsu_mem_ctrl;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_done;
    logic        exp_err;
    int          exp_re;
    int          exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];
  vec_t        vecs [27];
  int          checks;
  int          errors;

  lsu_mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h40] = 32'h8899AABB;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Starts on a negedge with the DUT idle and returns on the negedge after done.
  task automatic applyStimulus(input vec_t v, input int idx);
    int          re_cnt;
    int          we_cnt;
    int          done_cyc;
    logic        err_seen;
    logic [31:0] wd_seen;
    logic [31:0] addr_seen;
    logic [4:0]  proto;
    re_cnt = 0; we_cnt = 0; done_cyc = -1; err_seen = 1'b0;
    wd_seen = 32'd0; addr_seen = 32'd0; proto = 5'd0;
    req = 1'b1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (mem_re) begin re_cnt++; addr_seen = mem_addr; end
      if (mem_we) begin we_cnt++; addr_seen = mem_addr; wd_seen = mem_wdata; end
      if (!mem_re && !mem_we && (mem_addr != 32'd0 || mem_wdata != 32'd0)) proto[0] = 1'b1;
      if (!done && err) proto[1] = 1'b1;
      if (done_cyc >= 0 && k == done_cyc + 1) begin
        if (!ready) proto[2] = 1'b1;
        if (done) proto[3] = 1'b1;
        break;
      end
      if (ready) proto[4] = 1'b1;
      if (done) begin done_cyc = k; err_seen = err; end
    end
    checkOutput($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
    checkOutput($sformatf("v%0d_err", idx), {31'd0, err_seen}, {31'd0, v.exp_err});
    checkOutput($sformatf("v%0d_re_pulses", idx), re_cnt, v.exp_re);
    checkOutput($sformatf("v%0d_we_pulses", idx), we_cnt, v.exp_we);
    if (v.exp_we > 0) checkOutput($sformatf("v%0d_mem_wdata", idx), wd_seen, v.exp_wdata);
    if (v.exp_re + v.exp_we > 0)
      checkOutput($sformatf("v%0d_mem_addr", idx), addr_seen, {v.addr[31:2], 2'b00});
    checkOutput($sformatf("v%0d_protocol", idx), {27'd0, proto}, 32'd0);
    checkOutput($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
  endtask

  initial begin
    int acc;
    int dn;
    logic bad;
    checks = 0; errors = 0;
    rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;

    //           we  f3     addr          wdata         done err re we exp_wdata     exp_rdata
    vecs[0]  = '{1'b0, 3'd0, 32'h103, 32'h0,        2, 1'b0, 1, 0, 32'h0,        32'hFFFFFF88};
    vecs[1]  = '{1'b0, 3'd4, 32'h101, 32'h0,        2, 1'b0, 1, 0, 32'h0,        32'h000000AA};
    vecs[2]  = '{1'b0, 3'd5, 32'h102, 32'h0,        2, 1'b0, 1, 0, 32'h0,        32'h00008899};
    vecs[3]  = '{1'b0, 3'd1, 32'h100, 32'h0,        2, 1'b0, 1, 0, 32'h0,        32'hFFFFAABB};
    vecs[4]  = '{1'b1, 3'd0, 32'h101, 32'h12345677, 3, 1'b0, 1, 1, 32'h889977BB, 32'hFFFFAABB};
    vecs[5]  = '{1'b0, 3'd2, 32'h100, 32'h0,        2, 1'b0, 1, 0, 32'h0,        32'h889977BB};
    vecs[6]  = '{1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 2, 1'b0, 0, 1, 32'hDEADBEEF, 32'h889977BB};
    vecs[7]  = '{1'b0, 3'd2, 32'h104, 32'h0,        2, 1'b0, 1, 0, 32'h0,        32'hDEADBEEF};
    vecs[8]  = '{1'b1, 3'd2, 32'h102, 32'h11111111, 1, 1'b1, 0, 0, 32'h0,        32'hDEADBEEF};
    vecs[9]  = '{1'b0, 3'd1, 32'h101, 32'h0,        1, 1'b1, 0, 0, 32'h0,        32'hDEADBEEF};
    vecs[10] = '{1'b0, 3'd3, 32'h100, 32'h0,        1, 1'b1, 0, 0, 32'h0,        32'hDEADBEEF};
    vecs[11] = '{1'b1, 3'd1, 32'h106, 32'h1111CAFE, 3, 1'b0, 1, 1, 32'hCAFEBEEF, 32'hDEADBEEF};
    vecs[12] = '{1'b0, 3'd2, 32'h104, 32'h0,        2, 1'b0, 1, 0, 32'h0,        32'hCAFEBEEF};
    vecs[13] = '{1'b0, 3'd0, 32'h107, 32'h0,        2, 1'b0, 1, 0, 32'h0,        32'hFFFFFFCA};
    vecs[14] = '{1'b0, 3'd5, 32'h103, 32'h0,        1, 1'b1, 0, 0, 32'h0,        32'hFFFFFFCA};
    vecs[15] = '{1'b1, 3'd3, 32'h104, 32'h0,        1, 1'b1, 0, 0, 32'h0,        32'hFFFFFFCA};
    vecs[16] = '{1'b0, 3'd6, 32'h104, 32'h0,        1, 1'b1, 0, 0, 32'h0,        32'hFFFFFFCA};
    vecs[17] = '{1'b0, 3'd7, 32'h104, 32'h0,        1, 1'b1, 0, 0, 32'h0,        32'hFFFFFFCA};
    vecs[18] = '{1'b1, 3'd0, 32'h104, 32'h000000AB, 3, 1'b0, 1, 1, 32'hCAFEBEAB, 32'hFFFFFFCA};
    vecs[19] = '{1'b0, 3'd4, 32'h104, 32'h0,        2, 1'b0, 1, 0, 32'h0,        32'h000000AB};
    vecs[20] = '{1'b0, 3'd2, 32'h102, 32'h0,        1, 1'b1, 0, 0, 32'h0,        32'h000000AB};
    vecs[21] = '{1'b0, 3'd1, 32'h106, 32'h0,        2, 1'b0, 1, 0, 32'h0,        32'hFFFFCAFE};
    vecs[22] = '{1'b0, 3'd5, 32'h106, 32'h0,        2, 1'b0, 1, 0, 32'h0,        32'h0000CAFE};
    vecs[23] = '{1'b1, 3'd1, 32'h100, 32'h00007F01, 3, 1'b0, 1, 1, 32'h88997F01, 32'h0000CAFE};
    vecs[24] = '{1'b0, 3'd1, 32'h100, 32'h0,        2, 1'b0, 1, 0, 32'h0,        32'h00007F01};
    vecs[25] = '{1'b0, 3'd4, 32'h102, 32'h0,        2, 1'b0, 1, 0, 32'h0,        32'h00000099};
    vecs[26] = '{1'b0, 3'd2, 32'h100, 32'h0,        2, 1'b0, 1, 0, 32'h0,        32'h88997F01};

    repeat (2) @(negedge clk);
    checkOutput("reset_flags", {27'd0, ready, done, err, mem_re, mem_we}, 32'h10);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready", {31'd0, ready}, 32'd1);

    for (int i = 0; i < 26; i++) applyStimulus(vecs[i], i);

    $display("[TB] back-to-back lw with req held high");
    req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h100; wdata = 32'd0;
    acc = 0; dn = 0; bad = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      if (ready) begin acc++; if (k % 3 != 0) bad = 1'b1; end
      if (done) begin dn++; if (k % 3 != 2) bad = 1'b1; end
    end
    req = 1'b0;
    checkOutput("b2b_accepts", acc, 3);
    checkOutput("b2b_dones", dn, 3);
    checkOutput("b2b_spacing", {31'd0, bad}, 32'd0);
    checkOutput("b2b_rdata", rdata, 32'h88997F01);

    $display("[TB] reset during sh write-back");
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'd1; addr = 32'h100; wdata = 32'h00005555;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    checkOutput("rst_wb_we_before", {31'd0, mem_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_wb_flags", {27'd0, ready, done, err, mem_re, mem_we}, 32'h10);
    checkOutput("rst_wb_rdata", rdata, 32'd0);
    checkOutput("rst_wb_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_wb_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_wb_word_kept", mem[8'h40], 32'h88997F01);
    @(negedge clk);
    checkOutput("rst_wb_no_done", {30'd0, ready, done}, 32'h2);

    applyStimulus(vecs[26], 26);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
